mux_nto1_pipe: RTL and testbench
================================

MUX_NTO1_PIPE -- requirements
Module: mux_nto1_pipe

Interface
REQ-001 SHALL have parameter NCH, default 2, number of independent mux channels (1..16).
REQ-002 SHALL have parameter NIN, default 8, inputs per channel (2..64, need not be a power of 2).
REQ-003 SHALL have parameter W, default 1, data bits per input.
REQ-004 SHALL derive SW = ceil(log2(NIN)) as the per-channel select width (local, not overridable).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port in_vld, input, 1 bit: the input beat is valid.
REQ-008 SHALL have port in_rdy, output, 1 bit: the block accepts a beat this cycle; driven directly from a register.
REQ-009 SHALL have port in_data, input, NCH*NIN*W bits: channel c, input i occupies bits [(c*NIN+i)*W +: W].
REQ-010 SHALL have port in_sel, input, NCH*SW bits: the channel c select occupies bits [c*SW +: SW].
REQ-011 SHALL have port out_vld, output, 1 bit: the output beat is valid.
REQ-012 SHALL have port out_rdy, input, 1 bit: the downstream consumer accepts the beat.
REQ-013 SHALL have port out_data, output, NCH*W bits: the channel c result occupies bits [c*W +: W].
REQ-014 SHALL have port out_err, output, NCH bits: per-channel sticky select-range error flag.

Function
REQ-015 SHALL compute each channel result as in_data input in_sel[c] of channel c; a select value >= NIN SHALL yield all-zero data for that channel.
REQ-016 SHALL transfer an input beat when in_vld && in_rdy, and an output beat when out_vld && out_rdy.
REQ-017 SHALL register the result so that a beat accepted in cycle N appears on out_vld/out_data in cycle N+1 when the output register is empty (latency exactly 1).
REQ-018 SHALL implement a two-entry skid buffer with a main output register (M) and a skid register (S); state encoding is EMPTY (M and S invalid), ONE (M valid), and FULL (M and S valid).
REQ-019 Transitions SHALL be as follows:
- EMPTY with an input beat goes to ONE.
- ONE with an input beat and no output transfer goes to FULL.
- ONE with an output transfer and no input beat goes to EMPTY.
- ONE with both an input beat and an output transfer stays in ONE, and M loads the new beat.
- FULL with an output transfer goes to ONE, and M loads from S.
REQ-020 in_rdy SHALL be 1 in EMPTY and ONE, and 0 in FULL; no combinational path from out_rdy to in_rdy SHALL exist.
REQ-021 Beats SHALL leave in acceptance order, with no loss or duplication under any out_rdy pattern.
REQ-022 out_data and out_vld SHALL stay stable while out_vld && !out_rdy.
REQ-023 out_data SHALL be all-zero whenever out_vld=0.
REQ-024 Sustained throughput SHALL be one beat per cycle while out_rdy is held at 1.

Reset
REQ-025 SHALL, in the cycle after reset is sampled high, enter EMPTY with out_vld=0, out_data=0, out_err=0 and in_rdy=1.
REQ-026 A reset asserted mid-stream SHALL discard M and S contents; beats presented while reset=1 SHALL not be accepted.
REQ-027 in_rdy SHALL be 0 while reset is high.

Configuration
REQ-028 When the macro MUX_NTO1_SEL_CHECK_EN is defined, out_err[c] SHALL set in the cycle after a beat is accepted with in_sel[c] >= NIN, and hold until reset.
REQ-029 When MUX_NTO1_SEL_CHECK_EN is undefined, out_err SHALL be constant 0 and no range-check logic SHALL be built; the zero-data rule of REQ-015 still applies.
REQ-030 When NIN is a power of 2, out_err SHALL stay 0 in both builds.

Verification
REQ-031 Throughput case: defaults, in_data channel0=8'b1010_0110, sel0=2, channel1=8'hF0, sel1=7, in_vld=1 and out_rdy=1 held -> out_data=2'b11 one cycle later, one beat per cycle.
REQ-032 Backpressure case: out_rdy=0 with 3 beats offered -> 2 accepted, then in_rdy=0; out_rdy=1 -> beats emerge in order, the third is accepted the cycle after FULL clears.
REQ-033 Range-error case: NIN=6, W=4, macro defined, sel=7 -> that channel's data=0 and out_err bit=1 one cycle later, sticky; with the macro undefined -> data=0 and out_err=0.
REQ-034 Reset case: reset pulsed for 1 cycle in FULL -> out_vld=0, out_data=0, out_err=0, in_rdy=1 next cycle; no stale beat appears afterwards.
REQ-035 Random case: NCH=4, NIN=64, W=8, random in_vld/out_rdy for 10k cycles -> scoreboard matches every beat and out_data is stable whenever stalled.

Source files
------------

// File: rtl/mux_nto1_pipe.sv
// NCH independent NIN:1 muxes feeding a two-entry valid/ready skid buffer (M + S registers).
// Define MUX_NTO1_SEL_CHECK_EN to build the sticky per-channel select-range error flags.
module mux_nto1_pipe #(
   parameter int NCH = 2,
   parameter int NIN = 8,
   parameter int W   = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_vld,
   output logic                      in_rdy,
   input  logic [NCH*NIN*W-1:0]      in_data,
   input  logic [NCH*$clog2(NIN)-1:0] in_sel,
   output logic                      out_vld,
   input  logic                      out_rdy,
   output logic [NCH*W-1:0]          out_data,
   output logic [NCH-1:0]            out_err,
   output logic [1:0]                state_dbg
);

   localparam int SW = $clog2(NIN);

   // Handshake: a beat moves on a side exactly when that side's vld && rdy are both high
   // at a rising clk edge; vld never waits for rdy, and rdy never depends on out_rdy.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [NCH*W-1:0]   mux_res;
   logic [NCH*W-1:0]   m_q;
   logic [NCH*W-1:0]   s_q;
   logic               rdy_q;
   logic               accept;
   logic               pop;
   logic               m_load_new;
   logic               m_load_skid;
   logic               m_clear;
   logic               s_load;

`ifdef MUX_NTO1_SEL_CHECK_EN
   logic [NCH-1:0]     sel_bad;
   logic [NCH-1:0]     err_q;
`endif

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic [W-1:0]  tbl [NIN];
      logic [SW-1:0] sel;

      assign sel = in_sel[c*SW +: SW];

      for (genvar i = 0; i < NIN; i++) begin : g_in
         assign tbl[i] = in_data[(c*NIN+i)*W +: W];
      end

      // Selects past the last input return zero rather than aliasing another input.
      assign mux_res[c*W +: W] = (int'(sel) < NIN) ? tbl[sel] : '0;

`ifdef MUX_NTO1_SEL_CHECK_EN
      assign sel_bad[c] = (int'(sel) >= NIN);
`endif
   end

   // in_rdy is a registered flag, gated only by reset so nothing is taken while reset is high.
   assign in_rdy    = rdy_q && !reset;
   assign accept    = in_vld && in_rdy;
   assign out_vld   = (state != EMPTY);
   assign pop       = out_vld && out_rdy;
   assign out_data  = m_q;
   assign state_dbg = state;

   always_comb begin
      state_nxt   = state;
      m_load_new  = 1'b0;
      m_load_skid = 1'b0;
      m_clear     = 1'b0;
      s_load      = 1'b0;
      case (state)
         EMPTY: begin
            if (accept) begin
               state_nxt  = ONE;
               m_load_new = 1'b1;
            end
         end
         ONE: begin
            if (accept && pop) begin
               m_load_new = 1'b1;
            end else if (accept) begin
               state_nxt = FULL;
               s_load    = 1'b1;
            end else if (pop) begin
               state_nxt = EMPTY;
               m_clear   = 1'b1;
            end
         end
         FULL: begin
            if (pop) begin
               state_nxt   = ONE;
               m_load_skid = 1'b1;
            end
         end
         default: begin
            state_nxt = EMPTY;
            m_clear   = 1'b1;
         end
      endcase
   end

   // M is cleared whenever the buffer drains so out_data reads zero while out_vld is low.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= EMPTY;
         rdy_q <= 1'b1;
         m_q   <= '0;
         s_q   <= '0;
      end else begin
         state <= state_nxt;
         rdy_q <= (state_nxt != FULL);
         if (m_load_new) begin
            m_q <= mux_res;
         end else if (m_load_skid) begin
            m_q <= s_q;
         end else if (m_clear) begin
            m_q <= '0;
         end
         if (s_load) begin
            s_q <= mux_res;
         end
      end
   end

`ifdef MUX_NTO1_SEL_CHECK_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= '0;
      end else if (accept) begin
         err_q <= err_q | sel_bad;
      end
   end

   assign out_err = err_q;
`else
   assign out_err = '0;
`endif

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Bench for mux_nto1_pipe: three configurations (defaults, 4x64x8, 2x6x4) checked each cycle
// against a queue-based occupancy model; range-error expectations follow MUX_NTO1_SEL_CHECK_EN.
module tb_mux_nto1_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Instance a: defaults (NCH=2, NIN=8, W=1)
   logic        rst_a, in_vld_a, in_rdy_a, out_vld_a, out_rdy_a;
   logic [15:0] in_data_a;
   logic [5:0]  in_sel_a;
   logic [1:0]  out_data_a, out_err_a, st_a;

   // Instance b: NCH=4, NIN=64, W=8
   logic          rst_b, in_vld_b, in_rdy_b, out_vld_b, out_rdy_b;
   logic [2047:0] in_data_b;
   logic [23:0]   in_sel_b;
   logic [31:0]   out_data_b;
   logic [3:0]    out_err_b;
   logic [1:0]    st_b;

   // Instance e: NCH=2, NIN=6, W=4
   logic        rst_e, in_vld_e, in_rdy_e, out_vld_e, out_rdy_e;
   logic [47:0] in_data_e;
   logic [5:0]  in_sel_e;
   logic [7:0]  out_data_e;
   logic [1:0]  out_err_e, st_e;

   mux_nto1_pipe #(.NCH(2), .NIN(8), .W(1)) dut_a (
      .clk(clk), .reset(rst_a), .in_vld(in_vld_a), .in_rdy(in_rdy_a), .in_data(in_data_a),
      .in_sel(in_sel_a), .out_vld(out_vld_a), .out_rdy(out_rdy_a), .out_data(out_data_a),
      .out_err(out_err_a), .state_dbg(st_a));

   mux_nto1_pipe #(.NCH(4), .NIN(64), .W(8)) dut_b (
      .clk(clk), .reset(rst_b), .in_vld(in_vld_b), .in_rdy(in_rdy_b), .in_data(in_data_b),
      .in_sel(in_sel_b), .out_vld(out_vld_b), .out_rdy(out_rdy_b), .out_data(out_data_b),
      .out_err(out_err_b), .state_dbg(st_b));

   mux_nto1_pipe #(.NCH(2), .NIN(6), .W(4)) dut_e (
      .clk(clk), .reset(rst_e), .in_vld(in_vld_e), .in_rdy(in_rdy_e), .in_data(in_data_e),
      .in_sel(in_sel_e), .out_vld(out_vld_e), .out_rdy(out_rdy_e), .out_data(out_data_e),
      .out_err(out_err_e), .state_dbg(st_e));

   // Scoreboards: each queue holds the beats currently inside that DUT, oldest first.
   logic [31:0] q_a[$];
   logic [31:0] q_b[$];
   logic [31:0] q_e[$];
   logic [15:0] err_e = '0;
   logic        started_a = 1'b0, started_b = 1'b0, started_e = 1'b0;
   logic        stall_b = 1'b0;
   logic [31:0] last_b = '0;

   function automatic logic [31:0] mux_model(input logic [2047:0] d, input logic [23:0] s,
                                             input int nch, input int nin, input int w,
                                             input int sw);
      logic [31:0]   r;
      logic [23:0]   st;
      logic [2047:0] dt;
      logic [31:0]   part;
      int            sel;
      r = '0;
      for (int c = 0; c < nch; c++) begin
         st  = s >> (c * sw);
         sel = int'(st) & ((1 << sw) - 1);
         if (sel < nin) begin
            dt   = d >> ((c * nin + sel) * w);
            part = dt[31:0] & ((32'd1 << w) - 32'd1);
            r    = r | (part << (c * w));
         end
      end
      return r;
   endfunction

   function automatic logic [15:0] err_model(input logic [23:0] s, input int nch, input int nin,
                                             input int sw);
      logic [15:0] r;
      logic [23:0] st;
      int          sel;
      r = '0;
      for (int c = 0; c < nch; c++) begin
         st  = s >> (c * sw);
         sel = int'(st) & ((1 << sw) - 1);
         if (sel >= nin) r[c] = 1'b1;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 25)
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Reference models: occupancy decides readiness; accepted beats queue, transfers pop.
   always @(posedge clk) begin : model_a
      bit acc, pop;
      if (rst_a) begin
         q_a.delete();
         started_a <= 1'b1;
      end else if (started_a) begin
         acc = in_vld_a && (q_a.size() < 2);
         pop = (q_a.size() > 0) && out_rdy_a;
         if (pop) void'(q_a.pop_front());
         if (acc) q_a.push_back(mux_model(2048'(in_data_a), 24'(in_sel_a), 2, 8, 1, 3));
      end
   end

   always @(posedge clk) begin : model_b
      bit acc, pop;
      if (rst_b) begin
         q_b.delete();
         started_b <= 1'b1;
         stall_b   = 1'b0;
      end else if (started_b) begin
         acc     = in_vld_b && (q_b.size() < 2);
         pop     = (q_b.size() > 0) && out_rdy_b;
         stall_b = (q_b.size() > 0) && !out_rdy_b;
         if (pop) void'(q_b.pop_front());
         if (acc) q_b.push_back(mux_model(in_data_b, in_sel_b, 4, 64, 8, 6));
      end
   end

   always @(posedge clk) begin : model_e
      bit acc, pop;
      if (rst_e) begin
         q_e.delete();
         started_e <= 1'b1;
         err_e     <= '0;
      end else if (started_e) begin
         acc = in_vld_e && (q_e.size() < 2);
         pop = (q_e.size() > 0) && out_rdy_e;
         if (pop) void'(q_e.pop_front());
         if (acc) begin
            q_e.push_back(mux_model(2048'(in_data_e), 24'(in_sel_e), 2, 6, 4, 3));
`ifdef MUX_NTO1_SEL_CHECK_EN
            err_e <= err_e | err_model(24'(in_sel_e), 2, 6, 3);
`endif
         end
      end
   end

   // Single compare process, away from the active edge.
   always @(negedge clk) begin
      if (started_a) begin
         check("a_in_rdy", 32'(in_rdy_a), 32'((q_a.size() < 2) && !rst_a));
         check("a_out_vld", 32'(out_vld_a), 32'(q_a.size() > 0));
         check("a_out_data", 32'(out_data_a), (q_a.size() > 0) ? q_a[0] : 32'd0);
         check("a_out_err", 32'(out_err_a), 32'd0);
      end
      if (started_b) begin
         check("b_in_rdy", 32'(in_rdy_b), 32'((q_b.size() < 2) && !rst_b));
         check("b_out_vld", 32'(out_vld_b), 32'(q_b.size() > 0));
         check("b_out_data", out_data_b, (q_b.size() > 0) ? q_b[0] : 32'd0);
         check("b_out_err", 32'(out_err_b), 32'd0);
         if (stall_b) check("b_stall_stable", out_data_b, last_b);
         last_b = out_data_b;
      end
      if (started_e) begin
         check("e_in_rdy", 32'(in_rdy_e), 32'((q_e.size() < 2) && !rst_e));
         check("e_out_vld", 32'(out_vld_e), 32'(q_e.size() > 0));
         check("e_out_data", 32'(out_data_e), (q_e.size() > 0) ? q_e[0] : 32'd0);
         check("e_out_err", 32'(out_err_e), 32'(err_e));
      end
   end

   initial begin
      logic [1:0] e_err1, e_err3;
      int         mode;
`ifdef MUX_NTO1_SEL_CHECK_EN
      e_err1 = 2'b01;
      e_err3 = 2'b11;
`else
      e_err1 = 2'b00;
      e_err3 = 2'b00;
`endif
      // clock/reset block
      rst_a = 1'b1; in_vld_a = 1'b0; out_rdy_a = 1'b1; in_data_a = '0; in_sel_a = '0;
      rst_b = 1'b1; in_vld_b = 1'b0; out_rdy_b = 1'b1; in_data_b = '0; in_sel_b = '0;
      rst_e = 1'b1; in_vld_e = 1'b0; out_rdy_e = 1'b1; in_data_e = '0; in_sel_e = '0;
      repeat (2) @(negedge clk);
      check("rst_out_vld", 32'(out_vld_a), 32'd0);
      check("rst_out_data", 32'(out_data_a), 32'd0);
      check("rst_in_rdy_low", 32'(in_rdy_a), 32'd0);
      #1 rst_a = 1'b0; rst_b = 1'b0; rst_e = 1'b0;
      @(negedge clk);
      check("rst_in_rdy_high", 32'(in_rdy_a), 32'd1);

      // Throughput: one beat per cycle, result one cycle after acceptance
      #1 in_data_a = {8'hF0, 8'b1010_0110}; in_sel_a = {3'd7, 3'd2}; in_vld_a = 1'b1;
      @(negedge clk);
      check("tp_first", 32'(out_data_a), 32'h3);
      #1 in_sel_a = {3'd3, 3'd1};
      @(negedge clk);
      check("tp_second", 32'(out_data_a), 32'h1);
      #1 in_sel_a = {3'd4, 3'd0};
      @(negedge clk);
      check("tp_third", 32'(out_data_a), 32'h2);
      check("tp_in_rdy", 32'(in_rdy_a), 32'd1);
      #1 in_vld_a = 1'b0;
      @(negedge clk);
      check("tp_drain", 32'(out_vld_a), 32'd0);

      // Backpressure: two accepted, third waits until FULL clears
      #1 out_rdy_a = 1'b0; in_vld_a = 1'b1; in_sel_a = {3'd4, 3'd1};
      @(negedge clk);
      check("bp_b1", 32'(out_data_a), 32'h3);
      #1 in_sel_a = {3'd0, 3'd0};
      @(negedge clk);
      check("bp_full_rdy", 32'(in_rdy_a), 32'd0);
      #1 in_sel_a = {3'd0, 3'd1};
      @(negedge clk);
      check("bp_held", 32'(out_data_a), 32'h3);
      check("bp_still_full", 32'(in_rdy_a), 32'd0);
      #1 out_rdy_a = 1'b1;
      @(negedge clk);
      check("bp_b2", 32'(out_data_a), 32'h0);
      check("bp_rdy_back", 32'(in_rdy_a), 32'd1);
      @(negedge clk);
      check("bp_b3", 32'(out_data_a), 32'h1);
      #1 in_vld_a = 1'b0;
      @(negedge clk);
      check("bp_empty", 32'(out_vld_a), 32'd0);

      // Reset while FULL, with a beat offered during reset
      #1 out_rdy_a = 1'b0; in_vld_a = 1'b1; in_sel_a = {3'd7, 3'd2};
      repeat (2) @(negedge clk);
      check("rf_full", 32'(in_rdy_a), 32'd0);
      #1 rst_a = 1'b1;
      @(negedge clk);
      check("rf_vld", 32'(out_vld_a), 32'd0);
      check("rf_data", 32'(out_data_a), 32'd0);
      check("rf_err", 32'(out_err_a), 32'd0);
      check("rf_rdy_in_rst", 32'(in_rdy_a), 32'd0);
      #1 rst_a = 1'b0; in_vld_a = 1'b0; out_rdy_a = 1'b1;
      @(negedge clk);
      check("rf_rdy_after", 32'(in_rdy_a), 32'd1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("rf_no_stale", 32'(out_vld_a), 32'd0);
      end

      // Range error on the non-power-of-2 instance
      #1;
      for (int i = 0; i < 6; i++) begin
         in_data_e[i*4 +: 4]     = 4'(i + 1);
         in_data_e[(6+i)*4 +: 4] = 4'(8 + i);
      end
      in_sel_e = {3'd3, 3'd7}; in_vld_e = 1'b1;
      @(negedge clk);
      check("re_data0", 32'(out_data_e), 32'hB0);
      check("re_err1", 32'(out_err_e), 32'(e_err1));
      #1 in_sel_e = {3'd5, 3'd2};
      @(negedge clk);
      check("re_data1", 32'(out_data_e), 32'hD3);
      check("re_sticky", 32'(out_err_e), 32'(e_err1));
      #1 in_sel_e = {3'd6, 3'd1};
      @(negedge clk);
      check("re_bound", 32'(out_data_e), 32'h02);
      check("re_err3", 32'(out_err_e), 32'(e_err3));
      #1 in_vld_e = 1'b0;
      @(negedge clk);
      check("re_idle_data", 32'(out_data_e), 32'd0);

      // Random traffic: mode 0 mixed, 1 full throughput, 2 heavy backpressure
      for (int cyc = 0; cyc < 10000; cyc++) begin
         @(negedge clk);
         #1;
         mode = (cyc / 1000) % 3;
         in_vld_a  = (mode == 1) || ($urandom_range(0, 99) < 70);
         in_vld_b  = (mode == 1) || ($urandom_range(0, 99) < 70);
         in_vld_e  = (mode == 1) || ($urandom_range(0, 99) < 70);
         out_rdy_a = (mode == 1) || ($urandom_range(0, 99) < ((mode == 2) ? 20 : 60));
         out_rdy_b = (mode == 1) || ($urandom_range(0, 99) < ((mode == 2) ? 20 : 60));
         out_rdy_e = (mode == 1) || ($urandom_range(0, 99) < ((mode == 2) ? 20 : 60));
         in_data_a = 16'($urandom);
         in_sel_a  = 6'($urandom);
         for (int j = 0; j < 64; j++) in_data_b[j*32 +: 32] = $urandom;
         in_sel_b  = 24'($urandom);
         rst_b     = ($urandom_range(0, 999) == 0);
         in_data_e = {16'($urandom), $urandom};
         in_sel_e  = 6'($urandom);
      end

      @(negedge clk);
      #1 in_vld_a = 1'b0; in_vld_b = 1'b0; in_vld_e = 1'b0; rst_b = 1'b0;
      out_rdy_a = 1'b1; out_rdy_b = 1'b1; out_rdy_e = 1'b1;
      repeat (5) @(negedge clk);
      check("drain_a", 32'(out_vld_a), 32'd0);
      check("drain_b", 32'(out_vld_b), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
